// File: rtl/slc3_trace_pkg.sv
// rtl/slc3_trace_pkg.sv - shared types and helpers for the SLC-3 trace buffer
package slc3_trace_pkg;

    localparam int TS_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        READ = 2'd3
    } trace_state_e;

    // Samples kept after the trigger so that the window exactly fills the buffer
    function automatic int post_n(input int depth, input int pre_trig);
        return depth - pre_trig - 1;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - single-clock trace storage, one write port and one registered read port
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int DW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Block-RAM style write and registered read; contents are not reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/slc3_trace_buffer.sv
// rtl/slc3_trace_buffer.sv - SLC-3 trace recorder top; optional timestamp field via TRACE_TIMESTAMP_EN
module slc3_trace_buffer
    import slc3_trace_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 64,
    parameter int PRE_TRIG = 16,
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = CHANNELS * WIDTH + TS_W
`else
    localparam int ENTRY_W = CHANNELS * WIDTH
`endif
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      arm,
    input  logic                      sample_valid,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic [WIDTH-1:0]          trig_value,
    input  logic                      trig_en,
    input  logic                      force_trig,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [ENTRY_W-1:0]        rd_data,
    output logic                      rd_last,
    output logic                      busy,
    output logic                      triggered,
    output logic [$clog2(DEPTH):0]    entries
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int POST_N = post_n(DEPTH, PRE_TRIG);
    localparam logic [CW-1:0] POST_N_C   = CW'(POST_N);
    localparam logic [CW-1:0] PRE_TRIG_C = CW'(PRE_TRIG);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] trig_ptr_q, trig_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] pre_cnt_q, pre_cnt_d;
    logic [CW-1:0] post_cnt_q, post_cnt_d;
    logic [CW-1:0] entries_q, entries_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          force_q, force_d;
    logic          triggered_q, triggered_d;
    logic          rd_valid_q, rd_valid_d;

    logic               ram_we;
    logic [ENTRY_W-1:0] ram_wdata;
    logic [ENTRY_W-1:0] ram_rdata;
    logic               trig_hit;
    logic               rd_fire;
    logic               rd_is_last;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle stamp, restarted with each arm so stamps are capture-relative
    always_ff @(posedge Clk) begin
        if (Reset || arm) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign ram_wdata = {ts_q, ch_data};
`else
    assign ram_wdata = ch_data;
`endif

    assign trig_hit   = sample_valid &&
                        (force_q || force_trig || (trig_en && (ch_data[WIDTH-1:0] == trig_value)));
    assign rd_fire    = rd_valid_q && rd_ready;
    assign rd_is_last = rd_valid_q && (rd_cnt_q == entries_q - CW'(1));

    // Capture FSM: pointers, counters and readout sequencing
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        trig_ptr_d  = trig_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        entries_d   = entries_q;
        rd_cnt_d    = rd_cnt_q;
        force_d     = force_q | force_trig;
        triggered_d = triggered_q;
        rd_valid_d  = rd_valid_q;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d     = PRE;
                    wptr_d      = '0;
                    pre_cnt_d   = '0;
                    post_cnt_d  = '0;
                    entries_d   = '0;
                    triggered_d = 1'b0;
                end
            end
            PRE, POST: begin
                if (arm) begin
                    // Restart drops any sample presented in the same cycle
                    state_d     = PRE;
                    wptr_d      = '0;
                    pre_cnt_d   = '0;
                    post_cnt_d  = '0;
                    entries_d   = '0;
                    triggered_d = 1'b0;
                end else if (sample_valid) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    if (state_q == PRE) begin
                        if (trig_hit) begin
                            trig_ptr_d  = wptr_q;
                            triggered_d = 1'b1;
                            post_cnt_d  = '0;
                            force_d     = 1'b0;
                            if (POST_N == 0) begin
                                state_d    = READ;
                                rd_ptr_d   = wptr_q - pre_cnt_q[AW-1:0];
                                entries_d  = pre_cnt_q + CW'(1);
                                rd_cnt_d   = '0;
                                rd_valid_d = 1'b0;
                            end else begin
                                state_d = POST;
                            end
                        end else if (pre_cnt_q != PRE_TRIG_C) begin
                            pre_cnt_d = pre_cnt_q + CW'(1);
                        end
                    end else begin
                        post_cnt_d = post_cnt_q + CW'(1);
                        if (post_cnt_q + CW'(1) == POST_N_C) begin
                            state_d    = READ;
                            rd_ptr_d   = trig_ptr_q - pre_cnt_q[AW-1:0];
                            entries_d  = pre_cnt_q + CW'(1) + POST_N_C;
                            rd_cnt_d   = '0;
                            rd_valid_d = 1'b0;
                        end
                    end
                end
            end
            READ: begin
                // RAM output lags the address by one cycle, so valid follows entry by one cycle
                rd_valid_d = 1'b1;
                if (rd_fire) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rd_cnt_d = rd_cnt_q + CW'(1);
                    if (rd_is_last) begin
                        state_d    = IDLE;
                        rd_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pointer registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            trig_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            entries_q   <= '0;
            rd_cnt_q    <= '0;
            force_q     <= 1'b0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            trig_ptr_q  <= trig_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            entries_q   <= entries_d;
            rd_cnt_q    <= rd_cnt_d;
            force_q     <= force_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Read address follows the next-state pointer so data holds steady while stalled
    trace_ram #(
        .DEPTH (DEPTH),
        .DW    (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (ram_wdata),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_valid_q ? ram_rdata : '0;
    assign rd_last   = rd_is_last;
    assign busy      = (state_q != IDLE);
    assign triggered = triggered_q;
    assign entries   = entries_q;

endmodule

// File: tb/tb_slc3_trace_buffer.sv
// tb/tb_slc3_trace_buffer.sv - scoreboard bench for slc3_trace_buffer
module tb_slc3_trace_buffer;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 8;
    localparam int PRE_TRIG = 3;
    localparam int POSTN    = DEPTH - PRE_TRIG - 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int DW = CHANNELS * WIDTH + 16;
`else
    localparam int DW = CHANNELS * WIDTH;
`endif

    logic                      Clk = 1'b0;
    logic                      Reset;
    logic                      arm;
    logic                      sample_valid;
    logic [CHANNELS*WIDTH-1:0] ch_data;
    logic [WIDTH-1:0]          trig_value;
    logic                      trig_en;
    logic                      force_trig;
    logic                      rd_ready;
    logic                      rd_valid;
    logic [DW-1:0]             rd_data;
    logic                      rd_last;
    logic                      busy;
    logic                      triggered;
    logic [3:0]                entries;

    slc3_trace_buffer #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .PRE_TRIG (PRE_TRIG)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .arm          (arm),
        .sample_valid (sample_valid),
        .ch_data      (ch_data),
        .trig_value   (trig_value),
        .trig_en      (trig_en),
        .force_trig   (force_trig),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .busy         (busy),
        .triggered    (triggered),
        .entries      (entries)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] smp[$];
    logic [63:0] expq[$];
    int          trig_idx;
    int          post_m;
    int          exp_len;
    bit          armed_m;
    bit          trig_m;
    bit          force_m;
    int          ts_gap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] pc);
        return {pc ^ 16'hC0DE, pc ^ 16'h00FF, pc + 16'h0100, pc};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic build_expected();
        int pre;
        pre = (trig_idx < PRE_TRIG) ? trig_idx : PRE_TRIG;
        expq.delete();
        for (int i = trig_idx - pre; i <= trig_idx + POSTN; i++) begin
            expq.push_back(mk(smp[i]));
        end
        exp_len = pre + 1 + POSTN;
    endtask

    task automatic model_reset();
        armed_m = 1'b1;
        trig_m  = 1'b0;
        post_m  = 0;
        smp.delete();
    endtask

    task automatic model_sample(input logic [15:0] pc);
        if (!armed_m) return;
        smp.push_back(pc);
        if (!trig_m) begin
            if (force_m || (trig_en && pc == trig_value)) begin
                trig_m   = 1'b1;
                force_m  = 1'b0;
                trig_idx = smp.size() - 1;
            end
        end else begin
            post_m++;
            if (post_m == POSTN) begin
                armed_m = 1'b0;
                build_expected();
            end
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [15:0] pc, input int gap);
        sample_valid = 1'b1;
        ch_data      = mk(pc);
        tick();
        sample_valid = 1'b0;
        model_sample(pc);
        for (int g = 1; g < gap; g++) tick();
    endtask

    task automatic readout(input int mode, input string tag);
        int          n;
        int          cyc;
        int          waitc;
        bit          stalled;
        logic [63:0] e;
        logic [DW-1:0] hold;
`ifdef TRACE_TIMESTAMP_EN
        logic [15:0] prev_ts;
        prev_ts = '0;
`endif
        n = 0;
        cyc = 0;
        waitc = 0;
        while (!rd_valid && waitc < 20) begin
            tick();
            waitc++;
        end
        chk({tag, "_valid_rise"}, rd_valid, 1);
        chk({tag, "_entries"}, entries, exp_len);
        while (expq.size() > 0 && cyc < 100 && rd_valid) begin
            rd_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            stalled  = 1'b0;
            if (rd_ready) begin
                e = expq.pop_front();
                chk({tag, "_data"}, rd_data[63:0], e);
                chk({tag, "_last"}, rd_last, expq.size() == 0);
`ifdef TRACE_TIMESTAMP_EN
                if (ts_gap > 0 && n > 0) chk({tag, "_ts_gap"}, 16'(rd_data[79:64] - prev_ts), ts_gap);
                prev_ts = rd_data[79:64];
`endif
                n++;
            end else begin
                stalled = 1'b1;
                hold    = rd_data;
            end
            tick();
            cyc++;
            if (stalled) chk({tag, "_stall_hold"}, rd_data[63:0], hold[63:0]);
            if (mode == 0 && expq.size() > 0) chk({tag, "_no_bubble"}, rd_valid, 1);
        end
        rd_ready = 1'b0;
        chk({tag, "_handshakes"}, n, exp_len);
        chk({tag, "_valid_drop"}, rd_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        Reset = 1'b1; arm = 1'b0; sample_valid = 1'b0; ch_data = '0;
        trig_value = '0; trig_en = 1'b0; force_trig = 1'b0; rd_ready = 1'b0;
        armed_m = 1'b0; trig_m = 1'b0; force_m = 1'b0; post_m = 0; exp_len = 0; ts_gap = 0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data[63:0], 0);
        chk("rst_last", rd_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trig", triggered, 0);
        chk("rst_entries", entries, 0);

        // Pre-trigger window, saturated pre count
        trig_en = 1'b1; trig_value = 16'h3005;
        do_arm();
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 5; i++) send(16'h3000 + 16'(i), 1);
        chk("t1_not_trig", triggered, 0);
        send(16'h3005, 1);
        chk("t1_trig", triggered, 1);
        for (int i = 6; i < 10; i++) send(16'h3000 + 16'(i), 1);
        readout(0, "t1");

        // Trigger on the very first sample
        trig_value = 16'h3000;
        do_arm();
        for (int i = 0; i < 5; i++) send(16'h3000 + 16'(i), 1);
        readout(0, "t2");

        // Back-pressure during readout
        trig_value = 16'h7005;
        do_arm();
        for (int i = 0; i < 10; i++) send(16'h7000 + 16'(i), 1);
        readout(1, "t3");

        // Forced trigger latched across idle cycles
        trig_en = 1'b0;
        do_arm();
        send(16'h4000, 1);
        send(16'h4001, 1);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        force_m = 1'b1;
        tick(); tick();
        chk("t4_not_trig", triggered, 0);
        for (int i = 2; i < 7; i++) send(16'h4000 + 16'(i), 1);
        readout(0, "t4");

        // Restart in POST, with a colliding sample dropped
        trig_en = 1'b1; trig_value = 16'h5003;
        do_arm();
        for (int i = 0; i < 6; i++) send(16'h5000 + 16'(i), 1);
        chk("t5_trig_old", triggered, 1);
        arm = 1'b1; sample_valid = 1'b1; ch_data = mk(16'h5EEE);
        tick();
        arm = 1'b0; sample_valid = 1'b0;
        model_reset();
        chk("t5_rearm_trig", triggered, 0);
        chk("t5_rearm_busy", busy, 1);
        trig_value = 16'h6004;
        for (int i = 0; i < 9; i++) send(16'h6000 + 16'(i), 1);
        readout(0, "t5");

        // Reset in the middle of readout
        trig_value = 16'h3002;
        do_arm();
        for (int i = 0; i < 7; i++) send(16'h3000 + 16'(i), 1);
        for (int w = 0; w < 20 && !rd_valid; w++) tick();
        chk("t6_valid", rd_valid, 1);
        rd_ready = 1'b1;
        tick(); tick();
        rd_ready = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        expq.delete();
        force_m = 1'b0;
        chk("t6_valid_off", rd_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_trig", triggered, 0);
        chk("t6_entries", entries, 0);
        chk("t6_data", rd_data[63:0], 0);

`ifdef TRACE_TIMESTAMP_EN
        // Timestamps across sparse samples
        trig_value = 16'h8003;
        do_arm();
        ts_gap = 3;
        for (int i = 0; i < 8; i++) send(16'h8000 + 16'(i), 3);
        readout(0, "t7");
        ts_gap = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
